// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcode/funct
// fields, ALU operations, extender modes and PC source codes.
package ctrl_encode_def;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_FAULT    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_LUI = 4'd8;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  function automatic logic fn_is_r_alu(input logic [5:0] fn);
    return fn inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL};
  endfunction

  function automatic logic [3:0] fn_alu_op(input logic [5:0] fn);
    case (fn)
      FN_ADDU: return ALU_ADD;
      FN_SUBU: return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between mc_ctrl (master) and the shared datapath/memory (slave).
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       INSTop;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic [1:0]       PCSrc;
  logic             IRWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             Link;
  logic             RegWrite;
  logic             ALUSrcA;
  logic             Shamt;
  logic [1:0]       ALUSrcB;
  logic [3:0]       ALUOp;
  logic [1:0]       EXTOp;
  logic             Retire;
  logic             Fault;
  logic [3:0]       State;
  logic [CNT_W-1:0] CycleCnt;
  logic [CNT_W-1:0] InstrCnt;

  modport master (
    input  INSTop, funct, zero, mem_ready,
    output PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst,
           Link, RegWrite, ALUSrcA, Shamt, ALUSrcB, ALUOp, EXTOp, Retire, Fault,
           State, CycleCnt, InstrCnt
  );

  modport slave (
    output INSTop, funct, zero, mem_ready,
    input  PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst,
           Link, RegWrite, ALUSrcA, Shamt, ALUSrcB, ALUOp, EXTOp, Retire, Fault,
           State, CycleCnt, InstrCnt
  );
endinterface

// File: rtl/mc_ctrl_wait_timer.sv
// Memory wait-state counter; flags a timeout when a stalled access has
// already waited WAIT_MAX cycles and memory is still not ready.
module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wait,
  input  logic i_ready,
  output logic o_timeout
);
  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] r_cnt;

  // Leaving a wait state always goes through a non-wait state or a ready cycle,
  // so clearing here is equivalent to clearing on entry.
  always_ff @(posedge clk) begin
    if (!rst || !i_wait || i_ready)
      r_cnt <= '0;
    else if (r_cnt != LIMIT)
      r_cnt <= r_cnt + CW'(1);
  end

  assign o_timeout = (WAIT_MAX != 0) && i_wait && !i_ready && (r_cnt == LIMIT);
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/
// write-back over a shared datapath, traps on bad opcodes and memory timeouts.
module mc_ctrl
  import ctrl_encode_def::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);
  state_e           r_state, w_next;
  logic [CNT_W-1:0] r_cycle_cnt, r_instr_cnt;
  logic             w_retire, w_wait_st, w_timeout;
  logic             w_is_r, w_r_alu, w_jr, w_jump, w_imm, w_mem, w_br;

  assign w_is_r  = (bus.INSTop == OP_RTYPE);
  assign w_r_alu = w_is_r && fn_is_r_alu(bus.funct);
  assign w_jr    = w_is_r && (bus.funct == FN_JR);
  assign w_jump  = w_jr || (bus.INSTop == OP_J) || (bus.INSTop == OP_JAL);
  assign w_imm   = bus.INSTop inside {OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI};
  assign w_mem   = bus.INSTop inside {OP_LW, OP_SW};
  assign w_br    = bus.INSTop inside {OP_BEQ, OP_BNE};

  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

  mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_wait   (w_wait_st),
    .i_ready  (bus.mem_ready),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSrc    = PC_PLUS4;
    bus.IRWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegDst   = 1'b0;
    bus.Link     = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.Shamt    = 1'b0;
    bus.ALUSrcB  = 2'd0;
    bus.ALUOp    = ALU_NOP;
    bus.EXTOp    = EXT_ZERO;
    bus.Fault    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        bus.MemRead = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          w_next      = S_DECODE;
        end else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        if      (w_r_alu) w_next = S_EXEC_R;
        else if (w_jump)  w_next = S_JUMP;
        else if (w_imm)   w_next = S_EXEC_I;
        else if (w_mem)   w_next = S_MEM_ADDR;
        else if (w_br)    w_next = S_BRANCH;
        else              w_next = S_FAULT;
      end
      S_EXEC_R: begin
        // Shifts take their amount from shamt, so port A leaves rs.
        bus.Shamt   = (bus.funct == FN_SLL) || (bus.funct == FN_SRL);
        bus.ALUSrcA = !bus.Shamt;
        bus.ALUOp   = fn_alu_op(bus.funct);
        w_next      = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.ALUOp   = (bus.INSTop == OP_ORI) ? ALU_OR :
                      (bus.INSTop == OP_LUI) ? ALU_LUI : ALU_ADD;
        bus.EXTOp   = (bus.INSTop == OP_ORI) ? EXT_ZERO :
                      (bus.INSTop == OP_LUI) ? EXT_LUI : EXT_SIGN;
        w_next      = S_WB_ALU;
      end
      S_WB_ALU: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = w_is_r;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.ALUOp   = ALU_ADD;
        bus.EXTOp   = EXT_SIGN;
        w_next      = (bus.INSTop == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) w_next = S_WB_MEM;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else if (w_timeout) w_next = S_FAULT;
      end
      S_WB_MEM: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALU_SUB;
        bus.EXTOp   = EXT_SIGN;
        bus.PCSrc   = PC_BRANCH;
        bus.PCWrite = (bus.INSTop == OP_BEQ) ? bus.zero : !bus.zero;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSrc    = w_jr ? PC_RS : PC_JUMP;
        bus.Link     = (bus.INSTop == OP_JAL);
        bus.RegWrite = (bus.INSTop == OP_JAL);
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_FAULT: bus.Fault = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_FAULT) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign bus.Retire   = w_retire;
  assign bus.State    = r_state;
  assign bus.CycleCnt = r_cycle_cnt;
  assign bus.InstrCnt = r_instr_cnt;
endmodule
